// File: rtl/serial_shift_controller.sv
// Parallel-to-serial shifter: accepts a DEPTH-bit word by valid/ready handshake and
// emits it LSB first, each bit held for DIV cycles, with gapless back-to-back words.
module serial_shift_controller #(
  parameter int DEPTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [DEPTH-1:0] sh;
  logic [BW-1:0]    bcnt;
  logic [DW-1:0]    dcnt;
  logic             last;
  logic             bit_end;
  logic             transfer;

  assign bit_end  = (dcnt == DW'(DIV - 1));
  assign last     = (bcnt == BW'(DEPTH - 1)) && bit_end;
  assign in_ready = !abort && ((state == IDLE) || last);
  assign transfer = in_valid && in_ready;

  // Outputs derive only from registered state, so async reset clears them at once.
  assign out       = (state == SHIFT) ? sh[0] : 1'b0;
  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign done      = (state == SHIFT) && last && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      bcnt  <= '0;
      dcnt  <= '0;
    end else if (abort) begin
      // Abort outranks both the final cycle and any pending transfer.
      if (state == SHIFT) begin
        state <= IDLE;
        sh    <= '0;
        bcnt  <= '0;
        dcnt  <= '0;
      end
    end else if (transfer) begin
      state <= SHIFT;
      sh    <= in_data;
      bcnt  <= '0;
      dcnt  <= '0;
    end else if (state == SHIFT) begin
      if (last) begin
        state <= IDLE;
        bcnt  <= '0;
        dcnt  <= '0;
      end else if (bit_end) begin
        sh   <= {1'b0, sh[DEPTH-1:1]};
        bcnt <= bcnt + BW'(1);
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_shift_controller.sv
// Directed bench: three controller instances (DIV=1, 2, 3) driven with hand-checked
// words, aborts and a mid-word asynchronous reset.
module tb_serial_shift_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] in_data1 = '0, in_data2 = '0, in_data3 = '0;
  logic in_valid1 = 0, in_valid2 = 0, in_valid3 = 0;
  logic abort1 = 0, abort2 = 0, abort3 = 0;
  logic in_ready1, in_ready2, in_ready3;
  logic out1, out2, out3;
  logic out_valid1, out_valid2, out_valid3;
  logic busy1, busy2, busy3;
  logic done1, done2, done3;

  int total = 0;
  int bad = 0;

  serial_shift_controller #(.DEPTH(8), .DIV(1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .abort(abort1), .out(out1), .out_valid(out_valid1),
    .busy(busy1), .done(done1));

  serial_shift_controller #(.DEPTH(8), .DIV(2)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .abort(abort2), .out(out2), .out_valid(out_valid2),
    .busy(busy2), .done(done2));

  serial_shift_controller #(.DEPTH(8), .DIV(3)) u3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .abort(abort3), .out(out3), .out_valid(out_valid3),
    .busy(busy3), .done(done3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer w to the DIV=1 instance and check all 8 serial bits; optionally wiggle
  // in_valid/in_data while busy to confirm stray offers are ignored.
  task automatic run_word1(input logic [7:0] w, input bit wiggle);
    in_data1  = w;
    in_valid1 = 1'b1;
    chk("w1_ready_idle", {31'd0, in_ready1}, 32'd1);
    tick();
    in_valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] wv;
      wv = w;
      chk($sformatf("w1_%02h_out%0d", w, i), {31'd0, out1}, {31'd0, wv[i]});
      chk($sformatf("w1_%02h_vld%0d", w, i), {31'd0, out_valid1}, 32'd1);
      chk($sformatf("w1_%02h_done%0d", w, i), {31'd0, done1}, (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("w1_%02h_rdy%0d", w, i), {31'd0, in_ready1}, (i == 7) ? 32'd1 : 32'd0);
      if (wiggle) begin
        in_valid1 = (i < 6) ? i[0] : 1'b0;
        in_data1  = ~w;
      end
      tick();
    end
    chk("w1_idle_busy", {31'd0, busy1}, 32'd0);
    chk("w1_idle_vld", {31'd0, out_valid1}, 32'd0);
    chk("w1_idle_out", {31'd0, out1}, 32'd0);
  endtask

  initial begin
    // Reset values while reset is held
    #2;
    chk("rst_ready", {31'd0, in_ready1}, 32'd1);
    chk("rst_out", {31'd0, out1}, 32'd0);
    chk("rst_vld", {31'd0, out_valid1}, 32'd0);
    chk("rst_busy", {31'd0, busy3}, 32'd0);
    chk("rst_done", {31'd0, done2}, 32'd0);
    #10 reset = 1'b0;
    tick();

    // A5 at DIV=1, then a word with stray offers while busy
    run_word1(8'hA5, 1'b0);
    run_word1(8'h96, 1'b1);

    // 01 at DIV=3: one bit high for 3 cycles, 24 cycles busy, done only on the last
    in_data3 = 8'h01;
    in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      chk($sformatf("d3_out%0d", c), {31'd0, out3}, (c < 3) ? 32'd1 : 32'd0);
      chk($sformatf("d3_busy%0d", c), {31'd0, busy3}, 32'd1);
      chk($sformatf("d3_done%0d", c), {31'd0, done3}, (c == 23) ? 32'd1 : 32'd0);
      tick();
    end
    chk("d3_end_busy", {31'd0, busy3}, 32'd0);

    // FF then 00 back to back at DIV=1 with in_valid held
    in_data1 = 8'hFF;
    in_valid1 = 1'b1;
    tick();
    in_data1 = 8'h00;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("b2b_out%0d", c), {31'd0, out1}, (c < 8) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_vld%0d", c), {31'd0, out_valid1}, 32'd1);
      chk($sformatf("b2b_done%0d", c), {31'd0, done1}, (c == 7 || c == 15) ? 32'd1 : 32'd0);
      if (c == 3) chk("b2b_rdy_mid", {31'd0, in_ready1}, 32'd0);
      if (c == 7) chk("b2b_rdy_last", {31'd0, in_ready1}, 32'd1);
      if (c == 8) in_valid1 = 1'b0;
      tick();
    end
    chk("b2b_end_vld", {31'd0, out_valid1}, 32'd0);

    // F0 at DIV=2 aborted in its 5th cycle, with a competing offer
    in_data2 = 8'hF0;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("ab_busy%0d", c), {31'd0, busy2}, 32'd1);
      tick();
    end
    abort2 = 1'b1;
    in_valid2 = 1'b1;
    in_data2 = 8'hFF;
    #1;
    chk("ab_ready", {31'd0, in_ready2}, 32'd0);
    chk("ab_done", {31'd0, done2}, 32'd0);
    tick();
    abort2 = 1'b0;
    in_valid2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ab_idle_busy%0d", c), {31'd0, busy2}, 32'd0);
      chk($sformatf("ab_idle_vld%0d", c), {31'd0, out_valid2}, 32'd0);
      chk($sformatf("ab_idle_out%0d", c), {31'd0, out2}, 32'd0);
      chk($sformatf("ab_idle_done%0d", c), {31'd0, done2}, 32'd0);
      tick();
    end

    // Abort in IDLE only blocks acceptance
    abort2 = 1'b1;
    in_valid2 = 1'b1;
    #1;
    chk("abi_ready", {31'd0, in_ready2}, 32'd0);
    tick();
    chk("abi_busy", {31'd0, busy2}, 32'd0);
    abort2 = 1'b0;
    in_valid2 = 1'b0;
    #1;
    chk("abi_ready_back", {31'd0, in_ready2}, 32'd1);
    tick();

    // 3C at DIV=1, async reset during bit 4, then 81
    in_data1 = 8'h3C;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("ar_bit4", {31'd0, out1}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_out", {31'd0, out1}, 32'd0);
    chk("ar_vld", {31'd0, out_valid1}, 32'd0);
    chk("ar_busy", {31'd0, busy1}, 32'd0);
    chk("ar_done", {31'd0, done1}, 32'd0);
    chk("ar_ready", {31'd0, in_ready1}, 32'd1);
    tick();
    chk("ar_hold_busy", {31'd0, busy1}, 32'd0);
    #2 reset = 1'b0;
    tick();
    chk("ar_post_vld", {31'd0, out_valid1}, 32'd0);
    run_word1(8'h81, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
